cp_inserter: RTL
================

// Module: cp_inserter
// PURPOSE
//  Cyclic-prefix inserter for the OFDM transmit chain, placed after the IFFT. Buffers one
//  N_FFT-sample time-domain symbol, then emits its last cp_len samples followed by all N_FFT.
//  Runtime-selectable prefix length (0..CP_MAX); valid/ready handshake on both sides.
// PARAMETERS
//  SAMPLE_W  32  sample width, packed {I,Q}, bits passed through untouched
//  N_FFT     64  samples per symbol, >=2
//  CP_MAX    16  largest supported prefix, 1..N_FFT-1
// PORTS
//  clk       in   1                  single clock, all logic rising-edge
//  rst       in   1                  synchronous reset, active-high
//  cp_len    in   clog2(CP_MAX+1)    prefix length; sampled when a symbol completes fill
//  in_data   in   SAMPLE_W           input sample
//  in_valid  in   1                  input sample present
//  in_last   in   1                  marks sample N_FFT-1 of a symbol
//  in_ready  out  1                  block accepts in_data this cycle
//  out_data  out  SAMPLE_W           output sample
//  out_valid out  1                  out_data valid
//  out_cp    out  1                  current output sample belongs to the prefix
//  out_last  out  1                  final body sample of the symbol
//  out_ready in   1                  downstream accepts out_data
//  sym_err   out  1                  one-cycle pulse on framing error
// BEHAVIOUR
//  - Transfer on either side only when valid&&ready in the same cycle.
//  - Reset: state=FILL, wr_idx=0, in_ready=1 (next cycle), out_valid=0, out_cp=0,
//    out_last=0, sym_err=0, out_data=0. Reset mid-symbol discards all buffered/in-flight data.
//  - Storage: one N_FFT x SAMPLE_W buffer, indexed by sample position.
//  - FSM FILL: in_ready=1. Accepted sample written to buf[wr_idx], wr_idx++.
//    * in_last on wr_idx<N_FFT-1: sym_err pulse, partial symbol dropped, wr_idx=0, stay FILL.
//    * wr_idx==N_FFT-1 accepted (in_last or not): latch cp_len as cp_q (clamp to CP_MAX),
//      wr_idx=0; if in_last was 0, sym_err pulses; go CP if cp_q>0 else BODY.
//      Read index starts at N_FFT-cp_q (CP) or 0 (BODY).
//  - CP: in_ready=0. Emits buf[N_FFT-cp_q .. N_FFT-1], out_cp=1. After cp_q transfers -> BODY.
//  - BODY: in_ready=0. Emits buf[0 .. N_FFT-1], out_cp=0; out_last=1 on buf[N_FFT-1].
//    On that transfer -> FILL; in_ready=1 the following cycle.
//  - Latency: out_valid rises exactly 1 cycle after the final input sample's transfer.
//  - With out_ready held 1: one output per cycle, no bubbles between CP and BODY; symbol
//    period = N_FFT input + N_FFT+cp_q output cycles (single buffer, no overlap).
//  - Backpressure: while out_valid&&!out_ready, out_data/out_cp/out_last are held stable;
//    out_valid never drops without a transfer except on rst.
//  - cp_len changes outside the latch cycle have no effect on the symbol in progress.
//  - Read/write index wraps are explicit compares against N_FFT-1, no power-of-2 requirement.
//  - in_valid ignored while in_ready=0; in_data/in_last are don't-care then.
// TESTING  (N_FFT=8, CP_MAX=4, samples = 0x10+k for index k)
//  1 cp_len=2, out_ready=1, 8 samples with in_last on 8th -> out 0x16,0x17 (out_cp=1),
//    then 0x10..0x17, out_last on 0x17; out_valid 1 cycle after last input; sym_err=0.
//  2 cp_len=0 -> exactly 8 outputs 0x10..0x17, out_cp never set; cp_len=4 -> 0x14..0x17 then body.
//  3 cp_len=3, out_ready toggled 1,0,0,1,... -> same 11-sample sequence, outputs stable
//    across stalled cycles, no duplicates or drops; in_ready=0 until out_last transfers.
//  4 in_last on 5th sample -> sym_err pulse 1 cycle, no output; next clean symbol emitted correctly.
//    8 samples without in_last -> sym_err pulse, symbol still emitted.
//  5 cp_len changed 2->4 during BODY of symbol A -> A keeps 2-sample prefix, symbol B gets 4.
//  6 rst asserted mid-CP -> next cycle out_valid=0, in_ready=1; fresh symbol emitted from index 0.

Source files
------------

// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: buffers one N_FFT-sample symbol, then replays its last
// cp_len samples as a prefix followed by the full symbol body.
module cp_inserter #(
    parameter int SAMPLE_W = 32,
    parameter int N_FFT    = 64,
    parameter int CP_MAX   = 16,
    localparam int CPW     = $clog2(CP_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CPW-1:0]      cp_len,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                out_valid,
    output logic                out_cp,
    output logic                out_last,
    input  logic                out_ready,
    output logic                sym_err,
    output logic [1:0]          dbg_state
);
    localparam int IDX_W = (N_FFT > 1) ? $clog2(N_FFT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FFT - 1);

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_CP   = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;

    // Handshake: a sample moves on either port only in a cycle where valid and
    // ready are both high; the producer holds data/valid stable until then.

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    wr_q, wr_d;
    logic [IDX_W-1:0]    rd_q, rd_d;
    logic                err_q, err_d;
    logic                we;
    logic [CPW-1:0]      cp_eff;
    logic [IDX_W-1:0]    rd_start;
    logic [SAMPLE_W-1:0] mem_q [N_FFT];

    assign cp_eff   = (cp_len > CPW'(CP_MAX)) ? CPW'(CP_MAX) : cp_len;
    assign rd_start = IDX_W'(N_FFT - int'(cp_eff));

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        we      = 1'b0;
        case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    we = 1'b1;
                    if (wr_q == LAST_IDX) begin
                        wr_d  = '0;
                        err_d = !in_last;
                        if (cp_eff != '0) begin
                            state_d = S_CP;
                            rd_d    = rd_start;
                        end else begin
                            state_d = S_BODY;
                            rd_d    = '0;
                        end
                    end else if (in_last) begin
                        // Short symbol: drop what was collected and restart.
                        err_d = 1'b1;
                        wr_d  = '0;
                    end else begin
                        wr_d = wr_q + IDX_W'(1);
                    end
                end
            end
            S_CP: begin
                if (out_ready) begin
                    if (rd_q == LAST_IDX) begin
                        rd_d    = '0;
                        state_d = S_BODY;
                    end else begin
                        rd_d = rd_q + IDX_W'(1);
                    end
                end
            end
            S_BODY: begin
                if (out_ready) begin
                    if (rd_q == LAST_IDX) begin
                        rd_d    = '0;
                        state_d = S_FILL;
                    end else begin
                        rd_d = rd_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            wr_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Sample storage needs no reset: outputs are gated by state.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_q] <= in_data;
        end
    end

    assign in_ready  = (state_q == S_FILL);
    assign out_valid = (state_q == S_CP) || (state_q == S_BODY);
    assign out_data  = out_valid ? mem_q[rd_q] : '0;
    assign out_cp    = (state_q == S_CP);
    assign out_last  = (state_q == S_BODY) && (rd_q == LAST_IDX);
    assign sym_err   = err_q;
    assign dbg_state = state_q;
endmodule
